// File: rtl/ysyx_22040125_mdu_pkg.sv
// Shared types, op bit indices and operand helpers for the iterative multiply/divide unit.
package ysyx_22040125_mdu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdu_state_e;

  localparam int unsigned OP_MUL = 0;
  localparam int unsigned OP_DIV = 1;
  localparam int unsigned OP_REM = 2;

  localparam int unsigned N_DWORD = 64;
  localparam int unsigned N_WORD  = 32;

  localparam logic [63:0] MIN_DWORD = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN_WORD  = 64'hFFFF_FFFF_8000_0000;

  // Word variants work on the low half, extended according to signedness.
  function automatic logic [63:0] ext_operand(logic [63:0] v, logic sgn, logic w);
    if (!w) return v;
    return sgn ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
  endfunction

  function automatic logic [63:0] word_fix(logic [63:0] v, logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

endpackage

// File: rtl/ysyx_22040125_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step; next-step values exposed
// so the controller can capture the final bit on the same edge.
module ysyx_22040125_div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic        w_check,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] quo_nxt,
  output logic [63:0] rem_nxt
);

  logic [63:0] quo_q, rem_q, dvs_q;
  logic [64:0] r_sh, diff;

  // The dividend is pre-shifted so its top N bits feed the remainder first.
  assign r_sh    = {rem_q, quo_q[63]};
  assign diff    = r_sh - {1'b0, dvs_q};
  assign quo_nxt = {quo_q[62:0], ~diff[64]};
  assign rem_nxt = diff[64] ? r_sh[63:0] : diff[63:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      quo_q <= w_check ? {dividend[31:0], 32'h0} : dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/ysyx_22040125_mdu_ctrl.sv
// Multiply/divide controller: IDLE/CALC/DONE FSM, shift-add multiplier and sign fix-up.
// Define YSYX_22040125_MDU_FAST_MUL_EN for a single-cycle combinational multiply.
module ysyx_22040125_mdu_ctrl
  import ysyx_22040125_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic        sgn,
  input  logic        w_check,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  mdu_state_e  state;
  logic [5:0]  cnt;
  logic        mul_q, quo_q, w_q, neg1_q, neg2_q;
  logic [63:0] mcand_q, mplier_q, acc_q, res_q;

  logic        fire, onehot, is_div, div_zero, div_ovf, fast_mul, neg1, neg2;
  logic [63:0] opa, opb, mag_a, mag_b, acc_nxt, quo_nxt, rem_nxt;
  logic [63:0] calc_raw, special_raw, fast_res;

  assign in_ready  = rst_n & ~flush & (state == StIdle);
  assign fire      = in_valid & in_ready;
  assign out_valid = (state == StDone);
  assign busy      = (state != StIdle);
  assign result    = res_q;

  assign opa      = ext_operand(src1, sgn, w_check);
  assign opb      = ext_operand(src2, sgn, w_check);
  assign onehot   = (op == 3'b001) | (op == 3'b010) | (op == 3'b100);
  assign is_div   = op[OP_DIV] | op[OP_REM];
  assign div_zero = (opb == 64'd0);
  assign div_ovf  = sgn & (opa == (w_check ? MIN_WORD : MIN_DWORD)) & (opb == '1);
  assign neg1     = sgn & opa[63];
  assign neg2     = sgn & opb[63];
  assign mag_a    = neg1 ? -opa : opa;
  assign mag_b    = neg2 ? -opb : opb;

  assign special_raw = div_zero ? (op[OP_DIV] ? '1 : opa) : (op[OP_DIV] ? opa : 64'd0);

`ifdef YSYX_22040125_MDU_FAST_MUL_EN
  assign fast_mul = op[OP_MUL];
  assign fast_res = opa * opb;
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign calc_raw = mul_q ? acc_nxt :
                    quo_q ? ((neg1_q ^ neg2_q) ? -quo_nxt : quo_nxt) :
                            (neg1_q ? -rem_nxt : rem_nxt);

  ysyx_22040125_div_core u_div_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (fire),
    .step     ((state == StCalc) & ~flush),
    .w_check  (w_check),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      mul_q    <= 1'b0;
      quo_q    <= 1'b0;
      w_q      <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
    end else if (flush) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: begin
          if (fire) begin
            mul_q    <= op[OP_MUL];
            quo_q    <= op[OP_DIV];
            w_q      <= w_check;
            neg1_q   <= neg1;
            neg2_q   <= neg2;
            mcand_q  <= opa;
            mplier_q <= opb;
            acc_q    <= '0;
            if (!onehot) begin
              state <= StDone;
              res_q <= '0;
            end else if (fast_mul) begin
              state <= StDone;
              res_q <= word_fix(fast_res, w_check);
            end else if (is_div && (div_zero || div_ovf)) begin
              state <= StDone;
              res_q <= word_fix(special_raw, w_check);
            end else begin
              state <= StCalc;
              cnt   <= w_check ? 6'(N_WORD - 1) : 6'(N_DWORD - 1);
            end
          end
        end
        StCalc: begin
          acc_q    <= acc_nxt;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[63:1]};
          if (cnt == 6'd0) begin
            state <= StDone;
            res_q <= word_fix(calc_raw, w_q);
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_mdu_ctrl.sv
// Self-checking bench for ysyx_22040125_mdu_ctrl: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ysyx_22040125_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic        sgn = 1'b0;
  logic        w_check = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22040125_mdu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sgn       (sgn),
    .w_check   (w_check),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

`ifdef YSYX_22040125_MDU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  function automatic logic [63:0] ext(logic [63:0] v, logic s, logic w);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
  endfunction

  // Reference result computed directly from the arithmetic definition of each op.
  function automatic logic [63:0] model_res(logic [2:0] o, logic s, logic w,
                                            logic [63:0] a0, logic [63:0] b0);
    logic [63:0] a, b, r, mn;
    a  = ext(a0, s, w);
    b  = ext(b0, s, w);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (o != 3'b001 && o != 3'b010 && o != 3'b100) return 64'd0;
    if (o == 3'b001) r = a * b;
    else if (b == 64'd0) begin
      if (o == 3'b010) r = '1;
      else r = a;
    end else if (s && a == mn && b == '1) begin
      if (o == 3'b010) r = a;
      else r = 64'd0;
    end else if (s) begin
      if (o == 3'b010) r = $signed(a) / $signed(b);
      else r = $signed(a) % $signed(b);
    end else begin
      if (o == 3'b010) r = a / b;
      else r = a % b;
    end
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int model_lat(logic [2:0] o, logic s, logic w,
                                   logic [63:0] a0, logic [63:0] b0);
    logic [63:0] a, b, mn;
    a  = ext(a0, s, w);
    b  = ext(b0, s, w);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (o != 3'b001 && o != 3'b010 && o != 3'b100) return 1;
    if (o == 3'b001 && FastMul) return 1;
    if (o != 3'b001 && (b == 64'd0 || (s && a == mn && b == '1))) return 1;
    return w ? 33 : 65;
  endfunction

  // Handshake one request, then scramble the inputs to prove they were latched.
  task automatic issue(input logic [2:0] o, input logic s, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op = o; sgn = s; w_check = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); sgn = 1'($urandom); w_check = 1'($urandom);
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
  endtask

  task automatic wait_out(output logic [63:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, busy, in_ready} !== 3'b001 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state got ov/busy/ir=%b%b%b res=%h want 001 res=0",
               out_valid, busy, in_ready, result);
    end
  endtask

  task automatic test_div_signed();
    logic [63:0] r; int lat;
    issue(3'b010, 1'b1, 1'b0, -64'sd7, 64'd2);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== -64'sd3 || lat != 65) begin
      n_fail++; $display("FAIL div_signed got=%h lat=%0d want=%h lat=65", r, lat, -64'sd3);
    end
    issue(3'b100, 1'b1, 1'b0, -64'sd7, 64'd2);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== '1 || lat != 65) begin
      n_fail++; $display("FAIL rem_signed got=%h lat=%0d want=all-ones lat=65", r, lat);
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] r; int lat;
    issue(3'b010, 1'b0, 1'b0, 64'h1234, 64'd0);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== '1 || lat != 1) begin
      n_fail++; $display("FAIL divu_zero got=%h lat=%0d want=all-ones lat=1", r, lat);
    end
    issue(3'b100, 1'b0, 1'b0, 64'h1234, 64'd0);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== 64'h1234 || lat != 1) begin
      n_fail++; $display("FAIL remu_zero got=%h lat=%0d want=1234 lat=1", r, lat);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] r; int lat;
    issue(3'b010, 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== 64'h8000_0000_0000_0000 || lat != 1) begin
      n_fail++; $display("FAIL div_ovf got=%h lat=%0d want=8000000000000000 lat=1", r, lat);
    end
    issue(3'b100, 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== 64'd0 || lat != 1) begin
      n_fail++; $display("FAIL rem_ovf got=%h lat=%0d want=0 lat=1", r, lat);
    end
  endtask

  task automatic test_mulw();
    logic [63:0] r; int lat, want_lat;
    want_lat = FastMul ? 1 : 33;
    issue(3'b001, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat != want_lat) begin
      n_fail++;
      $display("FAIL mulw got=%h lat=%0d want=fffffffffffffffe lat=%0d", r, lat, want_lat);
    end
  endtask

  task automatic test_flush();
    logic [63:0] r; int lat, seen;
    issue(3'b010, 1'b0, 1'b0, 64'd1000, 64'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_idle got busy/ov/ir=%b%b%b want=000", busy, out_valid, in_ready);
    end
    flush = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready got=%b want=1", in_ready);
    end
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_no_out got=%0d valid cycles want=0", seen);
    end
    issue(3'b010, 1'b0, 1'b0, 64'd1000, 64'd7);
    wait_out(r, lat);
    consume();
    n_tests++;
    if (r !== 64'd142 || lat != 65) begin
      n_fail++; $display("FAIL after_flush got=%h lat=%0d want=8e lat=65", r, lat);
    end
  endtask

  task automatic test_hold();
    logic [63:0] r, want; int lat, bad;
    want = model_res(3'b100, 1'b1, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7);
    issue(3'b100, 1'b1, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7);
    wait_out(r, lat);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || result !== want) bad++;
    end
    n_tests++;
    if (bad != 0 || r !== want) begin
      n_fail++; $display("FAIL done_hold got=%h bad_cycles=%0d want=%h", r, bad, want);
    end
    consume();
    n_tests++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL done_release got ov/busy/ir=%b%b%b want=001", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3'b010, 1'b1, 1'b0, 64'd99999, 64'd13);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ready got=%b want=0", in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, busy} !== 2'b00 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state got ov/busy=%b%b res=%h want 00 res=0",
               out_valid, busy, result);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_mid_no_out got=%0d valid cycles want=0", seen);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return {32'h0, $urandom};
      5:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [63:0] a, b, r, want; logic [2:0] o; logic s, w; int lat, want_lat, k;
    logic [2:0] bad_ops [5];
    bad_ops = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) o = bad_ops[$urandom_range(0, 4)];
      else o = 3'b001 << (k % 3);
      s = 1'($urandom); w = 1'($urandom);
      a = pick(); b = pick();
      want     = model_res(o, s, w, a, b);
      want_lat = model_lat(o, s, w, a, b);
      issue(o, s, w, a, b);
      wait_out(r, lat);
      consume();
      n_tests++;
      if (r !== want || lat != want_lat) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%b s=%b w=%b a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, o, s, w, a, b, r, lat, want, want_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_mulw();
    test_flush();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_mdu_ctrl.md
YSYX_22040125_MDU_CTRL -- requirements
Module: ysyx_22040125_mdu_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; there is no other clock or reset.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- op  in  3  one-hot: [0] mul, [1] div, [2] rem
- sgn  in  1  1=signed div/rem, 0=unsigned
- w_check  in  1  32-bit word variant
- src1  in  64  multiplicand / dividend
- src2  in  64  multiplier / divisor
- flush  in  1  abort any operation
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- result  out  64  result
- busy  out  1  high whenever state != IDLE

Function
REQ-003 SHALL use three states: IDLE, CALC, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-005 On handshake, SHALL latch op, sgn, w_check and operands; input changes after that have no effect.
REQ-006 With w_check=1, operands SHALL be src[31:0], sign-extended if sgn=1 and zero-extended otherwise; the iteration count N is 32 (64 when w_check=0).
REQ-007 Special cases SHALL go IDLE->DONE with no CALC cycles:
- divisor==0: div result all ones; rem result = dividend.
- Signed overflow (dividend = minimum negative value, divisor = -1): div result = dividend; rem result = 0.
REQ-008 Otherwise SHALL go IDLE->CALC, loading counter = N-1 and performing one iteration per CALC cycle; after the iteration at counter 0, SHALL go to DONE.
REQ-009 Multiply iteration: shift-add, one multiplier bit per cycle; result = low 64 bits of the product (low 32 bits when w_check=1).
REQ-010 Divide iteration: restoring, one quotient bit per cycle, on magnitudes when sgn=1.
REQ-011 Signed sign fix-up: quotient is negated when operand signs differ; remainder takes the dividend's sign.
REQ-012 With w_check=1, result SHALL be bit 31 of the raw result sign-extended to 64 bits, for all ops.
REQ-013 Latency from the handshake edge to the first out_valid SHALL be N+1 cycles (iterative) or 1 cycle (special case).
REQ-014 In DONE, out_valid=1 and result SHALL be held stable until out_ready=1.
REQ-015 out_valid&out_ready SHALL return the state to IDLE; a new request is accepted no earlier than the following cycle.
REQ-016 flush=1 in any state SHALL force IDLE at the next edge:
- out_valid=0 from that edge on;
- any partial result is discarded;
- flush overrides a simultaneous in_valid or out_ready.
REQ-017 If op is not one-hot at handshake, SHALL go to DONE with result=0.

Reset
REQ-018 rst_n=0 at a clock edge SHALL force: state IDLE, out_valid=0, busy=0, result=0, counter=0, latched operands=0. Reset mid-CALC aborts the operation with no output.
REQ-019 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-020 Macro YSYX_22040125_MDU_FAST_MUL_EN defined: mul SHALL go IDLE->DONE using a single-cycle combinational multiply (latency 1).
REQ-021 Macro undefined: mul SHALL use the REQ-009 iterative path (latency N+1).
REQ-022 Div/rem behaviour SHALL be identical with or without the macro.

Structure
REQ-023 Package ysyx_22040125_mdu_pkg SHALL hold:
- state enum;
- op bit indices;
- N_DWORD=64, N_WORD=32.
REQ-024 The iterative restoring divider datapath SHALL be sub-module ysyx_22040125_div_core (start, step, quotient/remainder registers); the FSM, multiply path and fix-up stay in the top module.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- div, sgn=1, w_check=0, src1=-7, src2=2 -> out_valid at cycle 65, result=-3; rem, same operands -> result=-1.
- divu, src2=0, src1=0x1234 -> out_valid at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF; remu -> 0x1234.
- div, sgn=1, src1=0x8000_0000_0000_0000, src2=-1 -> result=src1 after 1 cycle; rem -> 0.
- mulw, w_check=1, src1=0x7FFF_FFFF, src2=2 -> result=0xFFFF_FFFF_FFFF_FFFE; latency 33 without the macro, 1 with it.
- div accepted, flush asserted at cycle 10 -> IDLE at cycle 11, no out_valid; next request completes normally.
- DONE held with out_ready=0 for 5 cycles -> result stable, in_ready=0; rst_n=0 mid-CALC -> all outputs at reset values next cycle.
